// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front-end with credit-limited requests, in-order response buffer,
// and redirect flush that discards stale in-flight responses.
module fetch_queue #(
   parameter int XLEN = 32,
   parameter int DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h00010000)
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   output logic                         mem_req_o,
   output logic [XLEN-1:0]              mem_addr_o,
   input  logic                         mem_gnt_i,
   input  logic                         mem_rvalid_i,
   input  logic [31:0]                  mem_rdata_i,
   input  logic                         redirect_i,
   input  logic [XLEN-1:0]              redirect_pc_i,
   output logic                         instr_valid_o,
   output logic [31:0]                  instr_o,
   output logic [XLEN-1:0]              instr_pc_o,
   input  logic                         instr_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   logic [XLEN-1:0] fetch_pc, rsp_pc;
   logic [CW-1:0]   count, inflight, discard, inflight_nx;
   logic [CW:0]     used;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [31:0]     buf_instr [DEPTH];
   logic [XLEN-1:0] buf_pc [DEPTH];
   logic            issue, rsp, push, pop;

   // Buffered plus in-flight never exceeds DEPTH, so a response always has a slot.
   assign used          = {1'b0, count} + {1'b0, inflight};
   assign mem_req_o     = !reset_i && !redirect_i && (used < (CW+1)'(DEPTH));
   assign mem_addr_o    = fetch_pc;
   assign issue         = mem_req_o && mem_gnt_i;
   assign rsp           = mem_rvalid_i && (inflight != '0);
   assign push          = rsp && (discard == '0) && !redirect_i;
   assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
   assign inflight_nx   = inflight + CW'(issue) - CW'(rsp);
   assign instr_valid_o = (count != '0);
   assign instr_o       = buf_instr[rd_ptr];
   assign instr_pc_o    = buf_pc[rd_ptr];
   assign count_o       = count;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         count    <= '0;
         inflight <= '0;
         discard  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else if (redirect_i) begin
         fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
         rsp_pc   <= {redirect_pc_i[XLEN-1:2], 2'b00};
         count    <= '0;
         inflight <= inflight_nx;
         discard  <= inflight_nx;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         fetch_pc <= issue ? fetch_pc + XLEN'(4) : fetch_pc;
         rsp_pc   <= push ? rsp_pc + XLEN'(4) : rsp_pc;
         count    <= count + CW'(push) - CW'(pop);
         inflight <= inflight_nx;
         discard  <= (rsp && discard != '0) ? discard - CW'(1) : discard;
         wr_ptr   <= push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr   <= pop ? rd_ptr + AW'(1) : rd_ptr;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         buf_instr[wr_ptr] <= mem_rdata_i;
         buf_pc[wr_ptr]    <= rsp_pc;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table plus hand-written redirect, credit, wrap and reset sequences.
module tb_fetch_queue;
   logic        clk_i = 0;
   logic        reset_i = 1;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i = 0;
   logic        mem_rvalid_i = 0;
   logic [31:0] mem_rdata_i = 0;
   logic        redirect_i = 0;
   logic [31:0] redirect_pc_i = 0;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i = 0;
   logic [2:0]  count_o;

   fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h00010000)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
      .instr_ready_i(instr_ready_i), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        gnt, rvalid, ready;
      logic [31:0] rdata;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] instr, ipc;
      logic [2:0]  cnt;
   } vec_t;

   vec_t        tbl [8];
   logic [31:0] q [$];
   int          checks = 0;
   int          errors = 0;
   int          grants = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One cycle of the memory model: in-order responses, one per cycle, data = ~address.
   task automatic cyc(input logic g, input logic r, input logic rdy,
                      input logic rd = 1'b0, input logic [31:0] rpc = 32'h0);
      @(negedge clk_i);
      mem_gnt_i = g;
      instr_ready_i = rdy;
      redirect_i = rd;
      redirect_pc_i = rpc;
      if (r && q.size() > 0) begin
         mem_rvalid_i = 1;
         mem_rdata_i = ~q.pop_front();
      end else begin
         mem_rvalid_i = 0;
         mem_rdata_i = 0;
      end
      #1;
      if (mem_req_o && g) begin
         q.push_back(mem_addr_o);
         grants++;
      end
   endtask

   task automatic first_out(input string nm, input logic [31:0] epc);
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cyc(1, 1, 1);
         if (i == 0) chk({nm, " first addr"}, mem_addr_o, epc);
         if (instr_valid_o) begin
            seen = 1;
            chk({nm, " pc"}, instr_pc_o, epc);
            chk({nm, " data"}, instr_o, ~epc);
         end
      end
      chk({nm, " delivered"}, 32'(seen), 32'd1);
   endtask

   task automatic quiesce();
      repeat (10) cyc(0, 1, 1);
      chk("quiesce count", 32'(count_o), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b1, 1'b0, 1'b1, 32'h0,        1'b1, 32'h10000, 1'b0, 32'h0,        32'h0,     3'd0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 32'hA0000000, 1'b1, 32'h10004, 1'b0, 32'h0,        32'h0,     3'd0};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 32'hA0000001, 1'b1, 32'h10008, 1'b1, 32'hA0000000, 32'h10000, 3'd1};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 32'hA0000002, 1'b1, 32'h1000C, 1'b1, 32'hA0000001, 32'h10004, 3'd1};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 32'hA0000003, 1'b1, 32'h10010, 1'b1, 32'hA0000002, 32'h10008, 3'd1};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10010, 1'b1, 32'hA0000003, 32'h1000C, 3'd1};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 32'h10010, 1'b1, 32'hA0000003, 32'h1000C, 3'd1};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10010, 1'b0, 32'h0,        32'h0,     3'd0};

      repeat (2) @(posedge clk_i);
      #1;
      chk("reset req", 32'(mem_req_o), 0);
      chk("reset valid", 32'(instr_valid_o), 0);
      chk("reset count", 32'(count_o), 0);
      @(negedge clk_i);
      reset_i = 0;

      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         mem_gnt_i = tbl[i].gnt;
         mem_rvalid_i = tbl[i].rvalid;
         mem_rdata_i = tbl[i].rdata;
         instr_ready_i = tbl[i].ready;
         #1;
         chk($sformatf("vec%0d req", i), 32'(mem_req_o), 32'(tbl[i].req));
         chk($sformatf("vec%0d addr", i), mem_addr_o, tbl[i].addr);
         chk($sformatf("vec%0d valid", i), 32'(instr_valid_o), 32'(tbl[i].valid));
         chk($sformatf("vec%0d count", i), 32'(count_o), 32'(tbl[i].cnt));
         if (tbl[i].valid) begin
            chk($sformatf("vec%0d instr", i), instr_o, tbl[i].instr);
            chk($sformatf("vec%0d pc", i), instr_pc_o, tbl[i].ipc);
         end
      end

      // Credit exhaustion with decode stalled.
      grants = 0;
      repeat (6) cyc(1, 1, 0);
      chk("credit grants", 32'(grants), 4);
      chk("credit count", 32'(count_o), 4);
      chk("credit req", 32'(mem_req_o), 0);
      chk("credit head pc", instr_pc_o, 32'h10010);
      cyc(1, 1, 1);
      chk("pulse req", 32'(mem_req_o), 0);
      grants = 0;
      repeat (4) cyc(1, 1, 0);
      chk("pulse grants", 32'(grants), 1);
      chk("pulse count", 32'(count_o), 4);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 1);
         chk($sformatf("drain%0d valid", i), 32'(instr_valid_o), 1);
         chk($sformatf("drain%0d pc", i), instr_pc_o, 32'h10014 + 32'(4 * i));
         chk($sformatf("drain%0d data", i), instr_o, ~(32'h10014 + 32'(4 * i)));
      end
      cyc(0, 0, 0);
      chk("drained count", 32'(count_o), 0);

      // Redirect with three requests in flight.
      repeat (3) cyc(1, 0, 0);
      cyc(0, 0, 0, 1, 32'h00020003);
      chk("redir req low", 32'(mem_req_o), 0);
      first_out("redir", 32'h00020000);
      quiesce();

      // Redirect coinciding with a response and a pop.
      repeat (2) cyc(1, 0, 0);
      cyc(0, 1, 0);
      cyc(0, 1, 1, 1, 32'h00030000);
      chk("rdpop req low", 32'(mem_req_o), 0);
      chk("rdpop valid before", 32'(instr_valid_o), 1);
      cyc(0, 0, 0);
      chk("rdpop count", 32'(count_o), 0);
      chk("rdpop valid", 32'(instr_valid_o), 0);
      chk("rdpop req", 32'(mem_req_o), 1);
      chk("rdpop addr", mem_addr_o, 32'h00030000);
      first_out("rdpop", 32'h00030000);
      quiesce();

      // Address wrap at the top of the space.
      cyc(0, 0, 0, 1, 32'hFFFFFFFC);
      first_out("wrap", 32'hFFFFFFFC);
      cyc(1, 1, 1);
      chk("wrap next valid", 32'(instr_valid_o), 1);
      chk("wrap next pc", instr_pc_o, 32'h0);
      chk("wrap next data", instr_o, 32'hFFFFFFFF);
      quiesce();

      // Asynchronous reset mid-stream, then stray responses.
      repeat (2) cyc(1, 0, 0);
      #2 reset_i = 1;
      #1;
      chk("async req", 32'(mem_req_o), 0);
      chk("async count", 32'(count_o), 0);
      chk("async valid", 32'(instr_valid_o), 0);
      @(posedge clk_i);
      #3 reset_i = 0;
      cyc(0, 1, 0);
      chk("post-reset req", 32'(mem_req_o), 1);
      chk("post-reset addr", mem_addr_o, 32'h00010000);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      chk("stray count", 32'(count_o), 0);
      chk("stray valid", 32'(instr_valid_o), 0);
      first_out("rst", 32'h00010000);
      quiesce();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
